// File: rtl/spi_byte_rx.sv
// SPI receive deserializer: synchronizes sclk/mosi/ss_n into clk48, assembles bytes
// and buffers them in a small FIFO drained through a valid/ready handshake.
`timescale 1ns/1ps
module spi_byte_rx #(
  parameter int DEPTH         = 4,
  parameter bit LSB_FIRST     = 1'b1,
  parameter bit SAMPLE_RISING = 1'b0
) (
  input  logic       clk48,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_ss_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       ovf,
  input  logic       ovf_clr,
  output logic       frame_err,
  output logic       busy,
  output logic       dbg_state_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic        sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic        ss_s1_q, ss_s2_q, ss_s3_q;
  logic        mosi_s1_q, mosi_s2_q;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shreg_q, shreg_d, shreg_next;
  logic        fe_q, fe_d;
  logic        ovf_q, ovf_d;
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]  mem_q [DEPTH];
  logic        sample_edge, ss_fall, ss_rise;
  logic        push, pop, push_ok, full, empty;

  // Handshake: a byte transfers on any clk48 rising edge where rx_valid and rx_ready are both 1.
  always_ff @(posedge clk48) begin
    if (rst) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      ss_s1_q   <= 1'b1;
      ss_s2_q   <= 1'b1;
      ss_s3_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sclk_s1_q <= spi_sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      ss_s1_q   <= spi_ss_n;
      ss_s2_q   <= ss_s1_q;
      ss_s3_q   <= ss_s2_q;
      mosi_s1_q <= spi_mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  assign sample_edge = SAMPLE_RISING ? (sclk_s2_q & ~sclk_s3_q) : (~sclk_s2_q & sclk_s3_q);
  assign ss_fall     = ~ss_s2_q & ss_s3_q;
  assign ss_rise     = ss_s2_q & ~ss_s3_q;
  assign shreg_next  = LSB_FIRST ? {mosi_s2_q, shreg_q[7:1]} : {shreg_q[6:0], mosi_s2_q};

  // An ss_n rise takes priority over a coincident sample edge.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    push     = 1'b0;
    fe_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ss_fall) begin
          state_d  = S_SHIFT;
          bitcnt_d = 3'd0;
          shreg_d  = 8'd0;
        end
      end
      S_SHIFT: begin
        if (ss_rise) begin
          state_d = S_IDLE;
          fe_d    = (bitcnt_q != 3'd0);
        end else if (sample_edge) begin
          shreg_d  = shreg_next;
          bitcnt_d = bitcnt_q + 3'd1;
          push     = (bitcnt_q == 3'd7);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop     = ~empty & rx_ready;
  assign push_ok = push & (~full | pop);

  // A new overflow outranks a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (push && full && !pop) ovf_d = 1'b1;
    else if (ovf_clr)         ovf_d = 1'b0;
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bitcnt_q <= 3'd0;
      shreg_q  <= 8'd0;
      fe_q     <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      fe_q     <= fe_d;
      ovf_q    <= ovf_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk48) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= shreg_next;
  end

  assign rx_valid    = ~empty;
  assign rx_data     = empty ? 8'd0 : mem_q[rd_ptr_q[AW-1:0]];
  assign ovf         = ovf_q;
  assign frame_err   = fe_q;
  assign busy        = (state_q == S_SHIFT);
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_spi_byte_rx.sv
// Bench for spi_byte_rx: directed scenarios plus randomized frames checked against a
// queue-based model of the receive FIFO, overflow flag and frame-error count.
`timescale 1ns/1ps
module tb_spi_byte_rx;
  localparam int DEPTH = 4;

  // clock / reset
  logic clk48 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk48 = ~clk48;

  logic sclk = 1'b0, mosi = 1'b0, ss_n = 1'b1, route = 1'b0;
  logic rx_ready = 1'b0, rx_ready2 = 1'b0, ovf_clr = 1'b0;
  logic sclk1, ss1, sclk2, ss2;
  logic [7:0] rx_data, rx_data2;
  logic rx_valid, ovf, frame_err, busy, dbg1;
  logic rx_valid2, ovf2, frame_err2, busy2, dbg2;

  assign sclk1 = route ? 1'b0 : sclk;
  assign ss1   = route ? 1'b1 : ss_n;
  assign sclk2 = route ? sclk : 1'b0;
  assign ss2   = route ? ss_n : 1'b1;

  spi_byte_rx #(.DEPTH(DEPTH), .LSB_FIRST(1'b1), .SAMPLE_RISING(1'b0)) dut (
    .clk48(clk48), .rst(rst), .spi_sclk(sclk1), .spi_mosi(mosi), .spi_ss_n(ss1),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .ovf(ovf),
    .ovf_clr(ovf_clr), .frame_err(frame_err), .busy(busy), .dbg_state_o(dbg1));

  spi_byte_rx #(.DEPTH(DEPTH), .LSB_FIRST(1'b0), .SAMPLE_RISING(1'b1)) dut2 (
    .clk48(clk48), .rst(rst), .spi_sclk(sclk2), .spi_mosi(mosi), .spi_ss_n(ss2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready2), .ovf(ovf2),
    .ovf_clr(ovf_clr), .frame_err(frame_err2), .busy(busy2), .dbg_state_o(dbg2));

  // scoreboard state
  logic [7:0] exp_q[$];
  logic       ovf_exp = 1'b0;
  int         fe_exp = 0, fe_cnt = 0, fe2_cnt = 0;
  int         n_vec = 0, n_err = 0;
  logic       fe_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk48) begin
    if (frame_err) begin
      fe_cnt++;
      check("fe_one_cycle", {31'd0, fe_prev}, 0);
    end
    if (frame_err2) fe2_cnt++;
    fe_prev <= frame_err;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk48);
  endtask

  task automatic send_bit(input logic b, input bit rise_mode, input int h, input int tail);
    if (rise_mode) begin
      mosi = b; tick(h); sclk = 1'b1; tick(tail); sclk = 1'b0;
    end else begin
      sclk = 1'b1; mosi = b; tick(h); sclk = 1'b0; tick(tail);
    end
  endtask

  task automatic model_push(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else ovf_exp = 1'b1;
  endtask

  task automatic open_frame(input int h);
    ss_n = 1'b0; tick(h);
  endtask

  task automatic send_byte(input logic [7:0] b, input int h);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0, h, h);
    model_push(b);
  endtask

  task automatic send_partial(input int nbits, input int h);
    for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, h, h);
  endtask

  task automatic close_frame(input int h, input bit partial);
    ss_n = 1'b1;
    if (partial) fe_exp++;
    tick(h + 4);
  endtask

  task automatic drain(input int n);
    logic [7:0] e;
    rx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check("drain_valid", {31'd0, rx_valid}, 1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      check("drain_data", {24'd0, rx_data}, {24'd0, e});
      tick(1);
    end
    rx_ready = 1'b0;
    check("drain_after_valid", {31'd0, rx_valid}, {31'd0, exp_q.size() != 0});
  endtask

  initial begin
    logic [7:0] cur;
    int h, nb, extra, k;

    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_valid", {31'd0, rx_valid}, 0);
    check("rst_data", {24'd0, rx_data}, 0);
    check("rst_ovf", {31'd0, ovf}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_fe", {31'd0, frame_err}, 0);

    // single byte with latency check
    cur = 8'h92;
    open_frame(6);
    check("busy_in_frame", {31'd0, busy}, 1);
    for (int i = 0; i < 7; i++) send_bit(cur[i], 1'b0, 6, 6);
    sclk = 1'b1; mosi = cur[7]; tick(6); sclk = 1'b0;
    tick(1); check("lat_edge0", {31'd0, rx_valid}, 0);
    tick(1); check("lat_edge1", {31'd0, rx_valid}, 0);
    tick(1); check("lat_edge2", {31'd0, rx_valid}, 1);
    model_push(cur);
    drain(1);
    tick(3);
    close_frame(6, 1'b0);
    check("single_fe", fe_cnt, fe_exp);

    // burst into a full FIFO, then overflow
    open_frame(6);
    send_byte(8'h01, 6); send_byte(8'h80, 6); send_byte(8'hA5, 6); send_byte(8'h3C, 6);
    check("burst_valid", {31'd0, rx_valid}, 1);
    check("burst_ovf0", {31'd0, ovf}, {31'd0, ovf_exp});
    send_byte(8'hFF, 6);
    check("burst_ovf1", {31'd0, ovf}, {31'd0, ovf_exp});
    close_frame(6, 1'b0);
    drain(4);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0; ovf_exp = 1'b0;
    check("ovf_clr", {31'd0, ovf}, {31'd0, ovf_exp});

    // partial frame, then a clean byte
    open_frame(6);
    send_partial(5, 6);
    close_frame(6, 1'b1);
    check("partial_fe", fe_cnt, fe_exp);
    check("partial_busy", {31'd0, busy}, 0);
    check("partial_nopush", {31'd0, rx_valid}, 0);
    open_frame(6); send_byte(8'h55, 6); close_frame(6, 1'b0);
    drain(1);

    // push and pop on the same edge while full
    open_frame(6);
    for (int j = 0; j < DEPTH; j++) send_byte(8'($urandom_range(0, 255)), 6);
    cur = 8'h6E;
    for (int i = 0; i < 7; i++) send_bit(cur[i], 1'b0, 6, 6);
    sclk = 1'b1; mosi = cur[7]; tick(6); sclk = 1'b0;
    tick(2);
    check("pp_valid", {31'd0, rx_valid}, 1);
    check("pp_head", {24'd0, rx_data}, {24'd0, exp_q[0]});
    rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(cur);
    tick(3);
    close_frame(6, 1'b0);
    check("pp_ovf", {31'd0, ovf}, {31'd0, ovf_exp});
    drain(DEPTH);

    // reset mid-byte with FIFO loaded and ovf set
    open_frame(5);
    for (int j = 0; j < DEPTH + 1; j++) send_byte(8'($urandom_range(0, 255)), 5);
    check("pre_rst_ovf", {31'd0, ovf}, {31'd0, ovf_exp});
    send_partial(3, 5);
    rst = 1'b1; tick(1); rst = 1'b0;
    exp_q.delete(); ovf_exp = 1'b0;
    check("mid_rst_valid", {31'd0, rx_valid}, 0);
    check("mid_rst_data", {24'd0, rx_data}, 0);
    check("mid_rst_ovf", {31'd0, ovf}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_fe", {31'd0, frame_err}, 0);
    tick(3);
    ss_n = 1'b1; tick(10);
    check("post_rst_fe", fe_cnt, fe_exp);
    open_frame(6); send_byte(8'hC3, 6); close_frame(6, 1'b0);
    drain(1);

    // randomized frames against the model
    for (int it = 0; it < 14; it++) begin
      h     = $urandom_range(3, 7);
      nb    = $urandom_range(1, 3);
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      open_frame(h);
      for (int j = 0; j < nb; j++) send_byte(8'($urandom_range(0, 255)), h);
      send_partial(extra, h);
      close_frame(h, extra != 0);
      check("rnd_ovf", {31'd0, ovf}, {31'd0, ovf_exp});
      check("rnd_valid", {31'd0, rx_valid}, {31'd0, exp_q.size() != 0});
      check("rnd_fe", fe_cnt, fe_exp);
      k = $urandom_range(0, exp_q.size());
      drain(k);
      if ($urandom_range(0, 2) == 0) begin
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0; ovf_exp = 1'b0;
        check("rnd_ovf_clr", {31'd0, ovf}, {31'd0, ovf_exp});
      end
    end
    drain(exp_q.size());

    // MSB-first, rising-edge sampling instance
    route = 1'b1; tick(2);
    cur = 8'h92;
    ss_n = 1'b0; tick(6);
    for (int i = 0; i < 8; i++) send_bit(cur[7 - i], 1'b1, 6, 6);
    tick(3);
    ss_n = 1'b1; tick(10);
    check("sweep_valid", {31'd0, rx_valid2}, 1);
    check("sweep_data", {24'd0, rx_data2}, 32'h92);
    check("sweep_busy", {31'd0, busy2}, 0);
    check("sweep_fe", fe2_cnt, 0);
    rx_ready2 = 1'b1; tick(1); rx_ready2 = 1'b0;
    check("sweep_drained", {31'd0, rx_valid2}, 0);
    route = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
